// File: rtl/key_exp_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : key_exp_ctrl
// Description : Control and round-constant sequencer for the byte-serial
//               AES-128 key expansion datapath (key_expantion_top).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module key_exp_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int ADDR_W     = 6
) (
    input  logic              gated_clk_ff,
    input  logic              rst,
    input  logic              start,
    output logic              key_req,
    output logic              en_key_exp,
    output logic              key_selector,
    output logic              key_gen_sel,
    output logic              rcon_sel,
    output logic [7:0]        rcon_output,
    output logic              key_mem_we,
    output logic [ADDR_W-1:0] key_mem_addr,
    output logic              busy,
    output logic              done
);

    localparam int                 c_RND_W    = $clog2(NUM_ROUNDS + 2);
    localparam logic [c_RND_W-1:0] c_LAST_RND = c_RND_W'(NUM_ROUNDS);
    localparam logic [c_RND_W-1:0] c_FIRST_RND = c_RND_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_byte_cnt;
    logic [c_RND_W-1:0]  r_round_cnt;
    logic [7:0]          r_rcon;
    logic [7:0]          w_rcon_next;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                w_last_byte;
    logic                w_word_end;

    assign w_last_byte = (r_byte_cnt == 4'd15);
    // A 32-bit word completes on every fourth byte; the write lands one cycle later.
    assign w_word_end  = ((r_state == ST_LOAD) || (r_state == ST_EXPAND)) &&
                         (r_byte_cnt[1:0] == 2'd3);
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    always_ff @(posedge gated_clk_ff or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        key_req      = 1'b0;
        en_key_exp   = 1'b0;
        key_selector = 1'b0;
        key_gen_sel  = 1'b0;
        rcon_sel     = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                key_req    = 1'b1;
                en_key_exp = 1'b1;
                if (w_last_byte) begin
                    w_next_state = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                en_key_exp   = 1'b1;
                key_selector = 1'b1;
                key_gen_sel  = (r_byte_cnt <= 4'd3);
                rcon_sel     = (r_byte_cnt == 4'd0);
                if (w_last_byte && (r_round_cnt == c_LAST_RND)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gated_clk_ff or posedge rst) begin
        if (rst) begin
            r_byte_cnt  <= 4'd0;
            r_round_cnt <= '0;
            r_rcon      <= 8'h01;
            r_word_idx  <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
        end else begin
            r_we <= w_word_end;
            if (w_word_end) begin
                r_addr     <= r_word_idx;
                r_word_idx <= r_word_idx + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_byte_cnt  <= 4'd0;
                        r_round_cnt <= '0;
                        r_rcon      <= 8'h01;
                        r_word_idx  <= '0;
                    end
                end
                ST_LOAD: begin
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                    if (w_last_byte) begin
                        r_round_cnt <= c_FIRST_RND;
                    end
                end
                ST_EXPAND: begin
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                    if (w_last_byte) begin
                        r_round_cnt <= r_round_cnt + 1'b1;
                        r_rcon      <= w_rcon_next;
                    end
                end
                default: begin
                    r_byte_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign rcon_output  = r_rcon;
    assign key_mem_we   = r_we;
    assign key_mem_addr = r_addr;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire
